// File: rtl/div_result_bcd_pkg.sv
// ============================================================================
// Module  : div_pkg (package)
// Brief   : Shared types, constants and parameter check for div_result_bcd.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
    function automatic bit digits_legal(input int width, input int digits);
        longint unsigned p;
        longint unsigned maxv;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        maxv = (64'd1 << width) - 64'd1;
        return (p > maxv);
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_result_bcd_add3.sv
// ============================================================================
// Module  : bcd_add3_digit
// Brief   : Double-dabble correction for one BCD digit (+3 when >= 5).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_add3_digit (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

`default_nettype wire

// File: rtl/div_result_bcd.sv
// ============================================================================
// Module  : div_result_bcd
// Brief   : Iterative binary-to-BCD converter for a quotient/remainder pair.
//           Optional macro DIV_BCD_LZ_BLANK_EN enables leading-zero blanking.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_result_bcd
    import div_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_quot,
    input  logic [WIDTH-1:0]      in_rem,
    input  logic                  in_dbz,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_quot_bcd,
    output logic [4*DIGITS-1:0]   out_rem_bcd,
    output logic                  out_err,
    output logic                  busy
);

    localparam int c_bcd_w = 4 * DIGITS;
    localparam int c_cnt_w = $clog2(WIDTH + 1);

    generate
        if (!digits_legal(WIDTH, DIGITS)) begin : g_bad_digits
            $error("div_result_bcd: DIGITS too small for WIDTH");
        end
    endgenerate

    state_t               r_state;
    logic [WIDTH-1:0]     r_q_bin;
    logic [WIDTH-1:0]     r_r_bin;
    logic [c_bcd_w-1:0]   r_q_bcd;
    logic [c_bcd_w-1:0]   r_r_bcd;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_err;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic [c_bcd_w-1:0]   r_out_quot;
    logic [c_bcd_w-1:0]   r_out_rem;
    logic                 r_out_err;

    logic [c_bcd_w-1:0]   w_q_adj;
    logic [c_bcd_w-1:0]   w_r_adj;
    logic [c_bcd_w-1:0]   w_q_shift;
    logic [c_bcd_w-1:0]   w_r_shift;
    logic [c_bcd_w-1:0]   w_q_final;
    logic [c_bcd_w-1:0]   w_r_final;
    logic                 w_unused_msb;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_add3_digit u_q_add3 (
                .i_digit (r_q_bcd[4*g +: 4]),
                .o_digit (w_q_adj[4*g +: 4])
            );
            bcd_add3_digit u_r_add3 (
                .i_digit (r_r_bcd[4*g +: 4]),
                .o_digit (w_r_adj[4*g +: 4])
            );
        end
    endgenerate

    // The top adjusted bit always shifts out; it is zero for any legal DIGITS.
    assign w_unused_msb = ^{w_q_adj[c_bcd_w-1], w_r_adj[c_bcd_w-1]};
    assign w_q_shift    = {w_q_adj[c_bcd_w-2:0], r_q_bin[WIDTH-1]};
    assign w_r_shift    = {w_r_adj[c_bcd_w-2:0], r_r_bin[WIDTH-1]};

`ifdef DIV_BCD_LZ_BLANK_EN
    function automatic logic [c_bcd_w-1:0] f_blank(input logic [c_bcd_w-1:0] v,
                                                   input logic err);
        logic [c_bcd_w-1:0] o;
        logic               lead;
        o    = v;
        lead = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && (v[4*i +: 4] == 4'd0)) begin
                o[4*i +: 4] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
        if (err) begin
            o = {DIGITS{BCD_BLANK}};
        end
        return o;
    endfunction

    assign w_q_final = f_blank(w_q_shift, r_err);
    assign w_r_final = f_blank(w_r_shift, r_err);
`else
    assign w_q_final = w_q_shift;
    assign w_r_final = w_r_shift;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_q_bin     <= '0;
            r_r_bin     <= '0;
            r_q_bcd     <= '0;
            r_r_bcd     <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out_quot  <= '0;
            r_out_rem   <= '0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_q_bin    <= in_quot;
                        r_r_bin    <= in_rem;
                        r_err      <= in_dbz;
                        r_q_bcd    <= '0;
                        r_r_bcd    <= '0;
                        r_cnt      <= c_cnt_w'(WIDTH);
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_q_bcd <= w_q_shift;
                    r_r_bcd <= w_r_shift;
                    r_q_bin <= {r_q_bin[WIDTH-2:0], 1'b0};
                    r_r_bin <= {r_r_bin[WIDTH-2:0], 1'b0};
                    r_cnt   <= r_cnt - c_cnt_w'(1);
                    // Last bit: publish the post-shift value in the same edge.
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_out_quot  <= w_q_final;
                        r_out_rem   <= w_r_final;
                        r_out_err   <= r_err;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign busy         = r_busy;
    assign out_quot_bcd = r_out_quot;
    assign out_rem_bcd  = r_out_rem;
    assign out_err      = r_out_err;

endmodule

`default_nettype wire

// File: tb/tb_div_result_bcd.sv
// ============================================================================
// Module  : tb_div_result_bcd
// Brief   : Scoreboard bench for div_result_bcd (honours DIV_BCD_LZ_BLANK_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_result_bcd;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    typedef struct {
        logic [11:0] q;
        logic [11:0] r;
        logic        err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_quot;
    logic [7:0]   in_rem;
    logic         in_dbz;
    logic         out_valid;
    logic         out_ready;
    logic [11:0]  out_quot_bcd;
    logic [11:0]  out_rem_bcd;
    logic         out_err;
    logic         busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   hs_cyc   = 0;
    logic prev_ov  = 1'b0;
    exp_t sb[$];

    div_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_quot      (in_quot),
        .in_rem       (in_rem),
        .in_dbz       (in_dbz),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quot_bcd (out_quot_bcd),
        .out_rem_bcd  (out_rem_bcd),
        .out_err      (out_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] model_bcd(input int v, input logic err);
        logic [11:0] d;
        int          t;
        int          msd;
        t   = v;
        msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            d[4*i +: 4] = 4'(t % 10);
            if (t % 10 != 0) msd = i;
            t = t / 10;
        end
`ifdef DIV_BCD_LZ_BLANK_EN
        for (int i = 0; i < DIGITS; i++) begin
            if (i > msd || err) d[4*i +: 4] = 4'hF;
        end
`else
        if (err && msd < 0) d = 12'h000;
`endif
        return d;
    endfunction

    // Scoreboard push on handshake, compare/pop while a result is presented.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check_eq("in_ready_vs_busy", {31'd0, in_ready}, {31'd0, !busy});
            if (in_valid && in_ready) begin
                e.q   = model_bcd(int'(in_quot), in_dbz);
                e.r   = model_bcd(int'(in_rem), in_dbz);
                e.err = in_dbz;
                sb.push_back(e);
                hs_cyc = cyc + 1;
            end
            if (out_valid && !prev_ov)
                check_eq("latency", cyc - hs_cyc, WIDTH);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb[0];
                    check_eq("quot_bcd", {20'd0, out_quot_bcd}, {20'd0, e.q});
                    check_eq("rem_bcd",  {20'd0, out_rem_bcd},  {20'd0, e.r});
                    check_eq("err",      {31'd0, out_err},      {31'd0, e.err});
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
        prev_ov = out_valid;
    end

    task automatic send(input logic [7:0] q, input logic [7:0] r, input logic d);
        int n;
        n        = 0;
        in_quot  = q;
        in_rem   = r;
        in_dbz   = d;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) check_eq("send_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain_timeout", sb.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_busy"},      {31'd0, busy},      32'd0);
        check_eq({tag, "_quot"},      {20'd0, out_quot_bcd}, 32'd0);
        check_eq({tag, "_rem"},       {20'd0, out_rem_bcd},  32'd0);
        check_eq({tag, "_err"},       {31'd0, out_err},   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_quot = '0; in_rem = '0; in_dbz = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset");

        // Basic conversion and latency
        send(8'd255, 8'd0, 1'b0);
        drain();

        // Back-to-back pairs; second waits for IDLE
        send(8'd100, 8'd7, 1'b0);
        send(8'd9, 8'd99, 1'b0);
        drain();

        // Back-pressure with ignored input pulses
        out_ready = 1'b0;
        send(8'd123, 8'd45, 1'b0);
        while (!out_valid) begin @(posedge clk); #1; end
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 5 == 2);
            in_quot  = 8'(i);
            in_rem   = 8'(i + 1);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        #1 check_eq("single_transfer", {31'd0, out_valid}, 32'd0);

        // Reset mid-conversion discards the result
        send(8'd200, 8'd50, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check_reset_state("midreset");
        repeat (12) @(posedge clk);
        #1 check_eq("no_out_after_reset", {31'd0, out_valid}, 32'd0);
        send(8'd42, 8'd3, 1'b0);
        drain();

        // Divide-by-zero flag and leading-zero cases
        send(8'd255, 8'd0, 1'b1);
        send(8'd5, 8'd0, 1'b0);
        send(8'd0, 8'd10, 1'b0);
        drain();

        for (int i = 0; i < 6; i++) begin
            send(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_result_bcd.md
Name: div_result_bcd

Overview:
- Downstream stage of tt_um_unsigned_divider.
- Consumes one quotient/remainder pair with a valid/ready handshake.
- Converts both values to packed BCD with an iterative shift-add-3 (double dabble) sequence, one bit per cycle, both operands in parallel.
- Presents the digits to the 7-segment/output mux stage.

Parameters:
- WIDTH, 8, bit width of the quotient and of the remainder.
- DIGITS, 3, BCD digits per operand. Must satisfy 10^DIGITS > 2^WIDTH-1; violation is an elaboration error.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  quotient/remainder/dbz are valid.
- in_ready  out  1  block can accept a new pair.
- in_quot  in  WIDTH  unsigned quotient.
- in_rem  in  WIDTH  unsigned remainder.
- in_dbz  in  1  divide-by-zero flag from divider.
- out_valid  out  1  BCD result valid.
- out_ready  in  1  consumer accepts result.
- out_quot_bcd  out  4*DIGITS  packed BCD quotient, digit 0 in bits [3:0].
- out_rem_bcd  out  4*DIGITS  packed BCD remainder.
- out_err  out  1  latched in_dbz of this result.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- One clock (clk). Reset synchronous, active-high (rst).
- Reset (rst high at an edge), regardless of state:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, out_err=0.
  - out_quot_bcd and out_rem_bcd all zero; shift registers and bit counter cleared.
  - A conversion in flight is discarded, no output produced.
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_quot/in_rem into shift registers and in_dbz into an err flag; clear both BCD accumulators; counter=WIDTH; go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle, per operand: every BCD digit >=5 gets +3 (4-bit add, no carry out of digit); then {bcd,bin} shifts left 1.
  - Counter decrements. When the counter reaches 1 this cycle, the next state is DONE.
- DONE:
  - out_valid=1; outputs hold the final BCD and err, stable while out_ready=0.
  - On out_ready: out_valid drops next cycle, go to IDLE.
  - No new input accepted in the handoff cycle.
- Latency: input handshake at edge 0 → out_valid high after edge WIDTH (8 cycles).
  - Minimum throughput: one result per WIDTH+2 cycles.
- Output registers update only on entry to DONE; they keep the last result while in IDLE/SHIFT.
- in_valid while busy is ignored: no capture, input not consumed.
- Back-pressure: unbounded hold in DONE; no data loss.
- in_dbz=1: conversion runs normally on supplied values; out_err=1 with that result.
- Widths: accumulator 4*DIGITS bits; digit add-3 is combinational within the cycle.

Optional Feature:
- Macro DIV_BCD_LZ_BLANK_EN.
- Defined: in DONE outputs, leading zero digits of each operand are replaced with 4'hF (blank code), scanning from the MS digit down. Digit 0 is never blanked. When out_err=1, all digits of both outputs are 4'hF.
- Undefined: raw BCD with leading zeros; out_err does not alter digits.
- Handshake and latency are identical either way.

Decomposition:
- Package div_pkg:
  - state enum type (IDLE/SHIFT/DONE).
  - BCD_BLANK=4'hF.
  - Function for DIGITS legality check.
- Sub-module bcd_add3_digit: one 4-bit digit, out = in>=5 ? in+3 : in.
  - Instantiated 2*DIGITS times via generate.
- Top contains the FSM, counter, shift registers and the optional blanking logic.

Test Plan:
- Reset then quot=255, rem=0, out_ready=1 → out_valid exactly 8 cycles after handshake; out_quot_bcd=12'h255, out_rem_bcd=12'h000, out_err=0.
- quot=100, rem=7, then quot=9, rem=99 back-to-back → 12'h100/12'h007, then 12'h009/12'h099. in_ready low during SHIFT/DONE; second pair accepted only in IDLE.
- Back-pressure: out_ready=0 for 20 cycles after out_valid → outputs and out_valid stable; in_valid pulses during the hold are ignored; release gives one transfer only.
- rst asserted 4 cycles into SHIFT → next cycle in_ready=1, out_valid=0, busy=0, outputs 0; next conversion of quot=42, rem=3 gives 12'h042/12'h003.
- in_dbz=1, quot=255, rem=0 → out_err=1, digits 12'h255/12'h000 (macro off); with DIV_BCD_LZ_BLANK_EN all digits 4'hF.
- DIV_BCD_LZ_BLANK_EN, quot=5, rem=0 → out_quot_bcd=12'hFF5, out_rem_bcd=12'hFF0.
